ff256ct_input_packer: RTL and testbench
=======================================

// Module: ff256ct_input_packer
// PURPOSE
//  Upstream feeder for the FF256CT row stage.
//  - Accepts a byte-serial stream of GF(2^8) symbols over a valid/ready handshake.
//  - Packs each group of N_SYM symbols into one x_in vector; symbol k sits at bits [8k+7:8k].
//  - Presents complete vectors over a valid/ready handshake. The transform rows consume each vector combinationally.
//  - Two-slot ping-pong buffer: filling the next vector overlaps with a stalled consumer, so one byte per clock is sustained.
// PARAMETERS
//  N_SYM   8   symbols per output vector (transform size); CW = $clog2(N_SYM)
//  SYM_W   8   symbol width in bits (GF(2^8) element)
// PORTS
//  clk      in   1            single clock, rising edge
//  rst      in   1            asynchronous, active-high reset
//  s_valid  in   1            input symbol valid
//  s_ready  out  1            packer can accept a symbol this cycle
//  s_data   in   SYM_W        input symbol
//  s_last   in   1            symbol is the last of a frame; closes the vector early
//  m_valid  out  1            x_in vector valid
//  m_ready  in   1            consumer takes the vector this cycle
//  m_data   out  N_SYM*SYM_W  packed vector (symbol 0 at LSBs), drives x_in
//  m_len    out  CW+1         number of real symbols in m_data, 1..N_SYM
// BEHAVIOUR
//  Transfers
//  - An input transfer occurs on an edge where s_valid & s_ready.
//  - An output transfer occurs on an edge where m_valid & m_ready.
//  State
//  - Two slots, slot[0..1], each with a full flag, data and len.
//  - wr_sel selects the slot being filled; rd_sel the slot being presented.
//  - cnt (CW bits) is the write index within slot[wr_sel].
//  Combinational outputs
//  - s_ready = !full[wr_sel].
//  - m_valid = full[rd_sel].
//  - m_data = slot[rd_sel].data; m_len = slot[rd_sel].len.
//  Input transfer
//  - Write s_data into symbol cnt of slot[wr_sel].
//  - If cnt == N_SYM-1 or s_last:
//    - set full[wr_sel] and len = cnt+1;
//    - toggle wr_sel; cnt <= 0.
//  - Otherwise cnt <= cnt+1.
//  Zero padding
//  - When a slot closes early via s_last, symbols cnt+1..N_SYM-1 read as 0.
//  - Implementation: clear the slot's data when its first symbol (cnt==0) is written.
//  - Stale symbols from a previous vector never appear on m_data.
//  Output transfer
//  - Clear full[rd_sel]; toggle rd_sel.
//  - m_data/m_len of the freed slot are don't-care until it refills.
//  Latency
//  - The symbol that completes a vector is accepted at edge E; m_valid = 1 in the cycle after E.
//  - No combinational path from s_* to m_*.
//  - m_ready -> s_ready: no combinational path.
//  Boundary conditions
//  - Simultaneous input-complete and output transfer on the same edge:
//    - both take effect;
//    - when the slots differ, the set and the clear hit distinct flags;
//    - both slots in use with wr_sel == rd_sel cannot occur.
//  - Both slots full: s_ready = 0; cnt, wr_sel and data hold until a slot frees.
//    - The freed slot makes s_ready = 1 on the next cycle.
//  - m_valid & !m_ready: m_data and m_len stay stable until the transfer (AXI-style hold).
//  - s_last on the N_SYM-th symbol: identical to a normal full vector, len = N_SYM.
//  - s_data is ignored when s_valid = 0; s_last is ignored unless an input transfer occurs.
//  - Mid-vector, s_valid deasserting for any number of cycles preserves cnt and the partial data.
//  Reset (asynchronous assert, any time)
//  - full = 2'b00, wr_sel = rd_sel = 0, cnt = 0, slot data and len = 0.
//  - Outputs: s_ready = 1, m_valid = 0, m_data = 0, m_len = 0.
//  - A partial or pending vector is discarded; there is no output transfer in the reset cycle.
// TESTING
//  1. Stream 0x01..0x08, one per clock, m_ready=1 -> one vector m_data=64'h0807060504030201, m_len=8; m_valid exactly one cycle after the 8th accept.
//  2. Stream 0x01..0x18, m_ready=0 -> first two vectors buffered; s_ready drops after symbol 16 (0x10). Then raise m_ready -> 64'h0807..01, then 64'h100F..09, then 64'h1817..11 in order, no loss or duplication.
//  3. Symbols 0xAA,0xBB,0xCC with s_last on 0xCC, following a previous full vector of 0xFF -> m_data=64'h0000000000CCBBAA, m_len=3.
//  4. Random s_valid/m_ready backpressure over 1000 symbols with random s_last -> scoreboard matches packed vectors and lengths; m_data stable whenever m_valid & !m_ready.
//  5. Assert rst mid-vector after 5 symbols with one full vector pending -> m_valid=0 and s_ready=1 immediately. Next 8 symbols form a fresh vector with m_len=8.
//  6. Full slot presented with m_ready=1 while the 8th symbol of the other slot is accepted on the same edge -> next cycle m_valid=1 with the new vector, s_ready=1.

Source files
------------

// File: rtl/ff256ct_input_packer.sv
// Byte-serial GF(2^8) symbol packer feeding the FF256CT row stage.
// A two-slot ping-pong buffer lets one vector fill while the other waits for the consumer.
module ff256ct_input_packer #(
  parameter int N_SYM = 8,
  parameter int SYM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [SYM_W-1:0]         s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N_SYM*SYM_W-1:0]   m_data,
  output logic [$clog2(N_SYM):0]   m_len
);

  localparam int CW = $clog2(N_SYM);
  localparam int VW = N_SYM * SYM_W;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SYM - 1);

  logic [1:0]    r_full;
  logic          r_wr_sel;
  logic          r_rd_sel;
  logic [CW-1:0] r_cnt;
  logic [VW-1:0] r_data [2];
  logic [CW:0]   r_len  [2];

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_close;
  logic [VW-1:0] w_fill;
  logic [1:0]    w_full_nxt;
  logic [CW:0]   w_len_nxt;

  // All outputs are muxes of registered state only, so no s_* or m_ready path reaches them.
  assign s_ready    = ~r_full[r_wr_sel];
  assign m_valid    = r_full[r_rd_sel];
  assign m_data     = r_data[r_rd_sel];
  assign m_len      = r_len[r_rd_sel];

  assign w_in_xfer  = s_valid & s_ready;
  assign w_out_xfer = m_valid & m_ready;
  assign w_close    = w_in_xfer & ((r_cnt == LAST_IDX) | s_last);
  assign w_len_nxt  = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

  // The first symbol of a vector wipes the slot so an early close reads zero-padded.
  always_comb begin
    w_fill = '0;
    if (r_cnt == '0) begin
      w_fill = '0;
    end else begin
      w_fill = r_data[r_wr_sel];
    end
    w_fill[int'(r_cnt) * SYM_W +: SYM_W] = s_data;
  end

  // Set and clear land on distinct flags whenever both happen on one edge.
  always_comb begin
    w_full_nxt = r_full;
    if (w_close) begin
      w_full_nxt[r_wr_sel] = 1'b1;
    end else begin
      w_full_nxt[r_wr_sel] = r_full[r_wr_sel];
    end
    if (w_out_xfer) begin
      w_full_nxt[r_rd_sel] = 1'b0;
    end else begin
      w_full_nxt[r_rd_sel] = w_full_nxt[r_rd_sel];
    end
  end

  // Slot, pointer and write-index state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_cnt     <= '0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_in_xfer) begin
        r_data[r_wr_sel] <= w_fill;
        if (w_close) begin
          r_len[r_wr_sel] <= w_len_nxt;
          r_wr_sel        <= ~r_wr_sel;
          r_cnt           <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_out_xfer) begin
        r_rd_sel <= ~r_rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_ff256ct_input_packer.sv
// Scoreboard bench for ff256ct_input_packer: a driver builds expected vectors from the
// packing rules, an independent monitor pops and compares whenever the consumer takes one.
module tb_ff256ct_input_packer;

  localparam int N_SYM = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  len;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [3:0]  m_len;

  vec_t       sb[$];
  logic [7:0] cur[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         done     = 0;

  ff256ct_input_packer #(.N_SYM(8), .SYM_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_len(m_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference packing: collect accepted symbols, emit a vector at N_SYM symbols or on last.
  function automatic void model_accept(input logic [7:0] sd, input logic sl);
    vec_t v;
    cur.push_back(sd);
    if (cur.size() == N_SYM || sl) begin
      v.data = 64'h0;
      for (int i = 0; i < cur.size(); i++) v.data[i*8 +: 8] = cur[i];
      v.len = 4'(cur.size());
      sb.push_back(v);
      cur.delete();
    end
  endfunction

  task automatic cyc(input logic sv, input logic [7:0] sd, input logic sl, input logic mr,
                     output bit acc);
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = (sb.size() < 2);
    check("s_ready", s_ready, exp_rdy);
    s_valid = sv;
    s_data  = sd;
    s_last  = sl;
    m_ready = mr;
    acc = sv && exp_rdy;
    @(posedge clk);
    #1;
    if (acc) model_accept(sd, sl);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'(i * 37), 1'b1, 1'b1, acc);
  endtask

  // Monitor: checks m_valid every cycle, holds while stalled, pops on each output transfer.
  initial begin
    vec_t prev;
    vec_t e;
    bit   hold;
    hold = 0;
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      if (rst) begin
        hold = 0;
      end else begin
        check("m_valid", m_valid, sb.size() > 0);
        if (hold) begin
          check("hold_data", m_data, prev.data);
          check("hold_len", m_len, prev.len);
        end
        if (sb.size() > 0 && m_ready) begin
          e = sb.pop_front();
          check("vec_data", m_data, e.data);
          check("vec_len", m_len, e.len);
          hold = 0;
        end else begin
          hold = m_valid && !m_ready;
          prev.data = m_data;
          prev.len  = m_len;
        end
      end
    end
  end

  initial begin
    bit acc;
    int k;
    int n;
    s_valid = 0; s_data = 0; s_last = 0; m_ready = 0;
    rst = 0;
    #1 rst = 1;
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 64'h0);
    check("rst_m_len", m_len, 4'd0);
    @(negedge clk);
    rst = 0;

    // Single full vector, consumer ready.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1, acc);
    check("t1_valid", m_valid, 1);
    check("t1_data", m_data, 64'h0807060504030201);
    check("t1_len", m_len, 4'd8);
    idle(3);

    // Consumer stalled: two vectors buffer, then drain in order.
    k = 1;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, 8'(k), 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    check("t2_stall_accepts", k, 17);
    for (int c = 0; c < 100 && k <= 24; c++) begin
      cyc(1'b1, 8'(k), 1'b0, 1'b1, acc);
      if (acc) k++;
    end
    idle(4);

    // Short vector after a full 0xFF vector must be zero padded.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'hFF, 1'b0, 1'b1, acc);
    cyc(1'b1, 8'hAA, 1'b0, 1'b1, acc);
    cyc(1'b1, 8'hBB, 1'b0, 1'b1, acc);
    cyc(1'b1, 8'hCC, 1'b1, 1'b1, acc);
    check("t3_data", m_data, 64'h0000000000CCBBAA);
    check("t3_len", m_len, 4'd3);
    idle(3);

    // Output transfer and completion of the other slot on the same edge.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, acc);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h37, 1'b0, 1'b1, acc);
    check("t6_valid", m_valid, 1);
    check("t6_s_ready", s_ready, 1);
    check("t6_data", m_data, 64'h3736353433323130);
    idle(3);

    // Reset mid-vector with a pending vector.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, acc);
    @(negedge clk);
    rst = 1; s_valid = 0; m_ready = 0;
    sb.delete();
    cur.delete();
    #1;
    check("t5_m_valid", m_valid, 0);
    check("t5_s_ready", s_ready, 1);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b1, acc);
    check("t5_data", m_data, 64'h6766656463626160);
    check("t5_len", m_len, 4'd8);
    idle(3);

    // Random traffic with backpressure and random frame ends.
    n = 0;
    for (int c = 0; c < 20000 && n < 1000; c++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 2) != 0), acc);
      if (acc) n++;
    end
    check("t4_symbols", n, 1000);
    for (int c = 0; c < 10 && cur.size() > 0; c++) cyc(1'b1, 8'h5A, 1'b1, 1'b1, acc);
    for (int c = 0; c < 50 && sb.size() > 0; c++) cyc(1'b0, 8'h00, 1'b0, 1'b1, acc);
    check("drain_empty", sb.size(), 0);

    done = 1;
    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
